// File: rtl/wb_intercon_decoder.sv
// Single-master Wishbone address decoder / response mux with a per-transfer bus watchdog.
// Latency: request edge 0 -> slave strobe after edge 0; slave response at edge k -> master termination after edge k+1.
// Backpressure: m_stall_o high from acceptance through the termination cycle; slave stall holds the strobe.
module wb_intercon_decoder #(
    parameter int          NUM_SLAVES  = 4,
    parameter logic [19:0] REGION_BASE = 20'h00000,
    parameter int          TIMEOUT     = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_reset_i,
    // master side
    input  logic                       m_cyc_i,
    input  logic                       m_stb_i,
    input  logic                       m_we_i,
    input  logic [31:0]                m_addr_i,
    input  logic [15:0]                m_data_i,
    input  logic [1:0]                 m_sel_i,
    output logic [15:0]                m_data_o,
    output logic                       m_ack_o,
    output logic                       m_err_o,
    output logic                       m_rty_o,
    output logic                       m_stall_o,
    // slave side
    output logic [NUM_SLAVES-1:0]      s_cyc_o,
    output logic [NUM_SLAVES-1:0]      s_stb_o,
    output logic                       s_we_o,
    output logic [31:0]                s_addr_o,
    output logic [15:0]                s_data_o,
    output logic [1:0]                 s_sel_o,
    input  logic [16*NUM_SLAVES-1:0]   s_data_i,
    input  logic [NUM_SLAVES-1:0]      s_ack_i,
    input  logic [NUM_SLAVES-1:0]      s_err_i,
    input  logic [NUM_SLAVES-1:0]      s_rty_i,
    input  logic [NUM_SLAVES-1:0]      s_stall_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // Termination kind carried from the slave phase into the RESP cycle.
    typedef enum logic [1:0] {
        RSP_ACK = 2'd0,
        RSP_ERR = 2'd1,
        RSP_RTY = 2'd2
    } rsp_t;

    state_t                  state_q, state_d;
    rsp_t                    rsp_q, rsp_d;
    logic [3:0]              idx_q, idx_d;
    logic [31:0]             addr_q, addr_d;
    logic [15:0]             wdat_q, wdat_d;
    logic                    we_q, we_d;
    logic [1:0]              sel_q, sel_d;
    logic [NUM_SLAVES-1:0]   cyc_q, cyc_d;
    logic [NUM_SLAVES-1:0]   stb_q, stb_d;
    logic [15:0]             rdat_q, rdat_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    rty_q, rty_d;
    logic                    stall_q, stall_d;
    logic [15:0]             wdog_q, wdog_d;

    logic [NUM_SLAVES-1:0]   req_onehot;
    logic                    req_mapped;
    logic                    sel_ack;
    logic                    sel_err;
    logic                    sel_rty;
    logic                    sel_stall;
    logic [15:0]             sel_rdat;

    // Address decode: an index beyond the populated slaves yields an all-zero one-hot, i.e. unmapped.
    always_comb begin
        req_onehot = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (m_addr_i[11:8] == 4'(k)) begin
                req_onehot[k] = 1'b1;
            end
        end
        req_mapped = (m_addr_i[31:12] == REGION_BASE) && (req_onehot != '0);
    end

    // Pick out the addressed slave's response; every other slave is ignored.
    always_comb begin
        sel_ack   = 1'b0;
        sel_err   = 1'b0;
        sel_rty   = 1'b0;
        sel_stall = 1'b0;
        sel_rdat  = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == 4'(k)) begin
                sel_ack   = s_ack_i[k];
                sel_err   = s_err_i[k];
                sel_rty   = s_rty_i[k];
                sel_stall = s_stall_i[k];
                sel_rdat  = s_data_i[16*k +: 16];
            end
        end
    end

    // Next-state and next-output logic; everything holds unless a branch says otherwise.
    always_comb begin
        state_d = state_q;
        rsp_d   = rsp_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        rdat_d  = rdat_q;
        stall_d = stall_q;
        wdog_d  = wdog_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rty_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (stall_q) begin
                    // Termination cycle: the master still shows the finished request, so don't re-accept it.
                    stall_d = 1'b0;
                end else if (m_cyc_i && m_stb_i) begin
                    idx_d   = m_addr_i[11:8];
                    addr_d  = m_addr_i;
                    wdat_d  = m_data_i;
                    we_d    = m_we_i;
                    sel_d   = m_sel_i;
                    stall_d = 1'b1;
                    if (req_mapped) begin
                        cyc_d   = req_onehot;
                        stb_d   = req_onehot;
                        wdog_d  = 16'd1;
                        state_d = REQ;
                    end else begin
                        rsp_d   = RSP_ERR;
                        state_d = RESP;
                    end
                end
            end

            REQ, WAIT: begin
                if (!m_cyc_i) begin
                    // Master abort: release the slave silently, any later response is ignored.
                    cyc_d   = '0;
                    stb_d   = '0;
                    stall_d = 1'b0;
                    wdog_d  = '0;
                    state_d = IDLE;
                end else if (sel_err || sel_rty || sel_ack) begin
                    cyc_d   = '0;
                    stb_d   = '0;
                    wdog_d  = '0;
                    state_d = RESP;
                    if (sel_err) begin
                        rsp_d = RSP_ERR;
                    end else if (sel_rty) begin
                        rsp_d = RSP_RTY;
                    end else begin
                        rsp_d = RSP_ACK;
                        if (!we_q) begin
                            rdat_d = sel_rdat;
                        end
                    end
                end else if (wdog_q == 16'(TIMEOUT)) begin
                    cyc_d   = '0;
                    stb_d   = '0;
                    wdog_d  = '0;
                    rsp_d   = RSP_ERR;
                    state_d = RESP;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                    if (state_q == REQ && !sel_stall) begin
                        stb_d   = '0;
                        state_d = WAIT;
                    end
                end
            end

            RESP: begin
                ack_d   = (rsp_q == RSP_ACK);
                err_d   = (rsp_q == RSP_ERR);
                rty_d   = (rsp_q == RSP_RTY);
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            state_q <= IDLE;
            rsp_q   <= RSP_ACK;
            idx_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            cyc_q   <= '0;
            stb_q   <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            stall_q <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            stall_q <= stall_d;
            wdog_q  <= wdog_d;
        end
    end

    assign m_data_o  = rdat_q;
    assign m_ack_o   = ack_q;
    assign m_err_o   = err_q;
    assign m_rty_o   = rty_q;
    assign m_stall_o = stall_q;
    assign s_cyc_o   = cyc_q;
    assign s_stb_o   = stb_q;
    assign s_we_o    = we_q;
    assign s_addr_o  = addr_q;
    assign s_data_o  = wdat_q;
    assign s_sel_o   = sel_q;

endmodule

// File: doc/wb_intercon_decoder.md
Name: wb_intercon_decoder

Overview:
- Single-master, multi-slave Wishbone address decoder and response multiplexer with a bus watchdog.
- Sits between the Wishbone master sequencer (upstream) and the peripheral slaves such as the LED block (downstream).
- Routes one transfer at a time to the slave selected by address, and returns that slave's data and ack/err/rty to the master.
- Terminates any transfer to an unmapped address, or any transfer that gets no response, with an error.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- REGION_BASE, 20'h00000, required value of address bits [31:12]; any other value is unmapped.
- TIMEOUT, 255, maximum cycles to wait for a slave response before forcing an error (1..65535).

Ports:
- wb_clk_i  in  1  clock, all logic on the rising edge.
- wb_reset_i  in  1  synchronous, active-high reset.
- m_cyc_i  in  1  master cycle.
- m_stb_i  in  1  master strobe.
- m_we_i  in  1  master write enable.
- m_addr_i  in  32  master address.
- m_data_i  in  16  master write data.
- m_sel_i  in  2  master byte selects.
- m_data_o  out  16  read data returned to the master.
- m_ack_o  out  1  normal termination, one-cycle pulse.
- m_err_o  out  1  error termination, one-cycle pulse.
- m_rty_o  out  1  retry termination, one-cycle pulse.
- m_stall_o  out  1  decoder busy; master must hold its request.
- s_cyc_o  out  NUM_SLAVES  per-slave cycle, one-hot or zero.
- s_stb_o  out  NUM_SLAVES  per-slave strobe, one-hot or zero.
- s_we_o  out  1  shared write enable.
- s_addr_o  out  32  shared latched address.
- s_data_o  out  16  shared latched write data.
- s_sel_o  out  2  shared latched byte selects.
- s_data_i  in  16*NUM_SLAVES  slave read data, slave k on bits [16k+15:16k].
- s_ack_i  in  NUM_SLAVES  slave acks.
- s_err_i  in  NUM_SLAVES  slave errors.
- s_rty_i  in  NUM_SLAVES  slave retries.
- s_stall_i  in  NUM_SLAVES  slave stalls.

Behaviour:
- Clock wb_clk_i, reset wb_reset_i: synchronous, active-high.
- Reset values: all outputs 0 (including m_stall_o), state IDLE, watchdog counter 0. Reset mid-transfer drops s_cyc_o/s_stb_o on the next edge; no response is sent to the master.
- Decode: slave index idx = m_addr_i[11:8]. A request is mapped iff m_addr_i[31:12]==REGION_BASE and idx<NUM_SLAVES.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - m_stall_o=0.
  - When m_cyc_i&m_stb_i: latch addr/data/we/sel and idx, set m_stall_o=1 on the next edge.
  - Mapped request: go to REQ and assert s_cyc_o[idx]=s_stb_o[idx]=1.
  - Unmapped request: go to RESP with pending err; no slave is touched.
- REQ:
  - Hold s_stb_o[idx] while s_stall_i[idx]=1.
  - On the first cycle with s_stall_i[idx]=0, drop s_stb_o on the next edge and go to WAIT; s_cyc_o stays 1.
  - If the slave responds during REQ, treat it as a WAIT response.
- WAIT: on s_ack_i[idx], s_err_i[idx] or s_rty_i[idx], capture s_data_i slice idx into m_data_o (ack and read only), drop s_cyc_o, go to RESP.
- Response priority when several are asserted together: err > rty > ack.
- Watchdog:
  - Counts cycles spent in REQ+WAIT, starting at 1 on entry to REQ.
  - If it reaches TIMEOUT with no response: drop s_cyc_o/s_stb_o, go to RESP with err.
  - A response arriving in the same cycle the count reaches TIMEOUT wins over the timeout.
- RESP:
  - Assert exactly one of m_ack_o/m_err_o/m_rty_o for exactly one cycle, with m_stall_o=1.
  - Then return to IDLE: terminations and m_stall_o drop to 0 on the next edge.
  - m_data_o holds its value until the next read ack.
- Latency: request sampled at edge 0, slave sees strobe from edge 1. Slave response sampled at edge k gives m_ack_o high after edge k+1. Zero-wait slave: master ack 3 cycles after request.
- Master abort: m_cyc_i=0 in REQ or WAIT drops the slave's cyc/stb on the next edge and goes to IDLE with no termination. Late slave responses are ignored.
- Responses or stalls from slaves other than idx are ignored in every state.
- Only one outstanding transfer at a time; a new request is accepted only in IDLE.

Test Plan:
- Write 16'h00A5 to addr 32'h0000_0100 with a zero-wait slave 1 -> s_cyc_o=4'b0010, s_data_o=16'h00A5, s_we_o=1; m_ack_o one-cycle pulse 3 cycles after request; other s_cyc_o bits 0 throughout.
- Read addr 32'h0000_0200 with slave 2 returning 16'h1234 after 5-cycle ack delay -> m_data_o=16'h1234 when m_ack_o=1; m_stall_o=1 from request+1 until m_ack_o falls.
- Access 32'h0001_0000 and 32'h0000_0500 (NUM_SLAVES=4) -> m_err_o pulse, s_cyc_o=0 throughout.
- Slave 0 never responds, TIMEOUT=8 -> s_cyc_o[0] drops and m_err_o pulses after 8 cycles in REQ+WAIT; next request is accepted normally.
- Slave 3 holds s_stall_i 3 cycles, then asserts ack and err together -> s_stb_o high 4 cycles; m_err_o=1, m_ack_o=0.
- Master drops m_cyc_i in WAIT, then a slave ack arrives; separately, wb_reset_i=1 mid-REQ -> no termination pulse, all outputs 0 next cycle, decoder back in IDLE.
